// File: rtl/cv32e40p_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_pkg
// Description : Shared types and constants for the register-file writeback
//               block: long-channel FIFO entry layout, L_DEPTH limits and
//               the destination-match helper used for hazard and busy
//               tracking.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_pkg;

    // Register address / data widths the FIFO entry layout is built for.
    localparam int c_rf_wb_addr_width = 5;
    localparam int c_rf_wb_data_width = 32;

    // Legal range of the long-channel FIFO depth.
    localparam int c_rf_wb_l_depth_min = 1;
    localparam int c_rf_wb_l_depth_max = 4;

    // One queued long-latency result: destination, pair flag, both halves.
    typedef struct packed {
        logic [c_rf_wb_addr_width-1:0] addr;
        logic                          is64;
        logic [c_rf_wb_data_width-1:0] lo;
        logic [c_rf_wb_data_width-1:0] hi;
    } rf_wb_entry_t;

    // True when entry e will write register r. The pair high half is
    // addr+1 taken modulo the register count, so an illegal pair at the
    // top register maps its high half onto x0, which never matches.
    function automatic logic rf_wb_targets(
        input rf_wb_entry_t                  e,
        input logic [c_rf_wb_addr_width-1:0] r
    );
        logic [c_rf_wb_addr_width-1:0] hi_addr;
        hi_addr = e.addr + 1'b1;
        return (r != '0) && ((e.addr == r) || (e.is64 && (hi_addr == r)));
    endfunction

endpackage : cv32e40p_pkg
`default_nettype wire

// File: rtl/cv32e40p_rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_rf_wb_fifo
// Description : Small circular FIFO for long-channel writeback entries.
//               Exposes the head plus every slot with its valid flag so the
//               parent can run hazard and busy checks over all pending
//               entries.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_push/i_push_data - write an entry (ignored when full)
//               i_pop            - drop the head (ignored when empty)
//               o_full/o_empty   - occupancy flags
//               o_head           - oldest entry
//               o_entries/o_valid- all slots and which are occupied
//               o_head_sel       - one-hot slot of the head (0 when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_rf_wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  T                 i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output T                 o_head,
    output T                 o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid,
    output logic [DEPTH-1:0] o_head_sel
);

    // A depth-1 FIFO still gets a 1-bit pointer that simply stays at 0.
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    T                     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage carries no reset; only the occupancy state decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is occupied when its distance from the read pointer (modulo
    // DEPTH) is below the current count.
    always_comb begin
        o_valid    = '0;
        o_head_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(r_rd_ptr) <= i) begin
                o_valid[i] = (i - int'(r_rd_ptr)) < int'(r_count);
            end else begin
                o_valid[i] = (i + DEPTH - int'(r_rd_ptr)) < int'(r_count);
            end
            o_head_sel[i] = (int'(r_rd_ptr) == i) && (r_count != '0);
        end
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;

endmodule : cv32e40p_rf_wb_fifo
`default_nettype wire

// File: rtl/cv32e40p_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_rf_writeback
// Description : Register-file writeback arbiter. The A channel writes
//               single-cycle results straight through port A; the L channel
//               queues long-latency/paired results in a FIFO that retires
//               one entry per cycle through port B. A requests stall while
//               any queued or incoming L entry targets the same register.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               a_*                        - single-cycle result channel
//               l_*                        - long-latency / pair channel
//               rf_*_a_o                   - register-file write port A
//               rf_*_b_o, rf_wdata_b1_o,
//               rf_instr64_oe_o            - register-file write port B
//               l_err_o                    - illegal pair retired
//               busy_o                     - pending-write vector
// Config      : CV32E40P_RF_WB_SCOREBOARD_EN adds the registered busy_o
//               scoreboard output.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_rf_writeback
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = c_rf_wb_addr_width,
    parameter int DATA_WIDTH = c_rf_wb_data_width,
    parameter int L_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // A channel
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_data_i,
    // L channel
    input  logic                    l_valid_i,
    output logic                    l_ready_o,
    input  logic [ADDR_WIDTH-1:0]   l_addr_i,
    input  logic                    l_is64_i,
    input  logic [DATA_WIDTH-1:0]   l_data_lo_i,
    input  logic [DATA_WIDTH-1:0]   l_data_hi_i,
    // Register file port A
    output logic [ADDR_WIDTH-1:0]   rf_waddr_a_o,
    output logic [DATA_WIDTH-1:0]   rf_wdata_a_o,
    output logic                    rf_we_a_o,
    // Register file port B
    output logic [ADDR_WIDTH-1:0]   rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0]   rf_wdata_b_o,
    output logic [DATA_WIDTH-1:0]   rf_wdata_b1_o,
    output logic                    rf_we_b_o,
    output logic                    rf_instr64_oe_o,
    output logic                    l_err_o
`ifdef CV32E40P_RF_WB_SCOREBOARD_EN
    ,
    output logic [2**ADDR_WIDTH-1:0] busy_o
`endif
);

    // The FIFO entry layout is fixed by the package, so the widths must
    // agree with it and the depth must stay within the supported range.
    generate
        if ((ADDR_WIDTH != c_rf_wb_addr_width) || (DATA_WIDTH != c_rf_wb_data_width) ||
            (L_DEPTH < c_rf_wb_l_depth_min) || (L_DEPTH > c_rf_wb_l_depth_max)) begin : g_param_check
            $error("cv32e40p_rf_writeback: unsupported ADDR_WIDTH/DATA_WIDTH/L_DEPTH");
        end
    endgenerate

    rf_wb_entry_t         w_l_entry;
    rf_wb_entry_t         w_head;
    rf_wb_entry_t         w_entries [L_DEPTH];
    logic [L_DEPTH-1:0]   w_valid;
    logic [L_DEPTH-1:0]   w_head_sel;
    logic [L_DEPTH-1:0]   w_keep;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_l_push;
    logic                 w_head_vld;
    logic                 w_pair_illegal;
    logic                 w_a_hazard;
    logic                 w_a_xfer;

    assign w_l_entry.addr = l_addr_i;
    assign w_l_entry.is64 = l_is64_i;
    assign w_l_entry.lo   = l_data_lo_i;
    assign w_l_entry.hi   = l_data_hi_i;

    // No bypass when full: a pop in the same cycle does not open the slot.
    assign l_ready_o = ~w_full;
    assign w_l_push  = l_valid_i & ~w_full;

    cv32e40p_rf_wb_fifo #(
        .DEPTH (L_DEPTH),
        .T     (rf_wb_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_l_push),
        .i_push_data (w_l_entry),
        .i_pop       (~w_empty),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_entries   (w_entries),
        .o_valid     (w_valid),
        .o_head_sel  (w_head_sel)
    );

    // Entries that survive the current edge (the head always retires).
    assign w_keep = w_valid & ~w_head_sel;

    // ------------------------------------------------------------------
    // A channel: stall on any pending or incoming L write to the same
    // register, since the L result is the older of the two.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_hazard = 1'b0;
        for (int i = 0; i < L_DEPTH; i++) begin
            if (w_keep[i] && rf_wb_targets(w_entries[i], a_addr_i)) begin
                w_a_hazard = 1'b1;
            end
        end
        if (w_head_vld && rf_wb_targets(w_head, a_addr_i)) begin
            w_a_hazard = 1'b1;
        end
        if (w_l_push && rf_wb_targets(w_l_entry, a_addr_i)) begin
            w_a_hazard = 1'b1;
        end
    end

    assign a_ready_o = ~w_a_hazard;

    // Qualified by rst_n so port A stays quiet while reset is held.
    assign w_a_xfer     = rst_n & a_valid_i & a_ready_o;
    assign rf_we_a_o    = w_a_xfer & (a_addr_i != '0);
    assign rf_waddr_a_o = w_a_xfer ? a_addr_i : '0;
    assign rf_wdata_a_o = w_a_xfer ? a_data_i : '0;

    // ------------------------------------------------------------------
    // Port B: the FIFO head retires every cycle it is valid.
    // ------------------------------------------------------------------
    assign w_head_vld     = ~w_empty;
    assign w_pair_illegal = w_head.is64 & (w_head.addr == '1);

    assign rf_we_b_o       = w_head_vld & (w_head.addr != '0);
    assign rf_waddr_b_o    = w_head_vld ? w_head.addr : '0;
    assign rf_wdata_b_o    = w_head_vld ? w_head.lo   : '0;
    assign rf_wdata_b1_o   = w_head_vld ? w_head.hi   : '0;
    assign rf_instr64_oe_o = w_head_vld & w_head.is64 & ~w_pair_illegal;
    assign l_err_o         = w_head_vld & w_pair_illegal;

`ifdef CV32E40P_RF_WB_SCOREBOARD_EN
    // ------------------------------------------------------------------
    // Scoreboard: registered image of the FIFO contents as they will be
    // after this edge (surviving entries plus the one being pushed).
    // ------------------------------------------------------------------
    logic [2**ADDR_WIDTH-1:0] r_busy;
    logic [2**ADDR_WIDTH-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = '0;
        for (int r = 1; r < 2**ADDR_WIDTH; r++) begin
            for (int i = 0; i < L_DEPTH; i++) begin
                if (w_keep[i] && rf_wb_targets(w_entries[i], c_rf_wb_addr_width'(r))) begin
                    w_busy_nxt[r] = 1'b1;
                end
            end
            if (w_l_push && rf_wb_targets(w_l_entry, c_rf_wb_addr_width'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_o = r_busy;
`endif

endmodule : cv32e40p_rf_writeback
`default_nettype wire
